// File: rtl/afifo_wr_arbiter_if.sv
// Write-side bus between afifo_wr_arbiter (master) and async_fifo (slave), wr_clk domain.
interface afifo_wr_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 8
) ();
  logic [DATA_WIDTH-1:0] din;
  logic                  wr_en;
  logic                  full;
  logic                  almost_full;
  logic                  wr_ack;
  logic                  wr_err;

  modport master (
    output din,
    output wr_en,
    input  full,
    input  almost_full,
    input  wr_ack,
    input  wr_err
  );

  modport slave (
    input  din,
    input  wr_en,
    output full,
    output almost_full,
    output wr_ack,
    output wr_err
  );
endinterface

// File: rtl/afifo_wr_arbiter.sv
// Round-robin bounded-burst arbiter feeding the async_fifo write port from NUM_REQ producers.
// Optional ack/err statistics counters are enabled by defining AFIFO_WR_STATS_EN.
module afifo_wr_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX_BURST  = 4
) (
  input  logic                          wr_clk_i,
  input  logic                          clear_i,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]            gnt_o,
  output logic [NUM_REQ-1:0]            pop_o,
  output logic                          busy_o,
  output logic                          err_flag_o,
`ifdef AFIFO_WR_STATS_EN
  output logic [15:0]                   ack_cnt_o,
  output logic [7:0]                    err_cnt_o,
`endif
  afifo_wr_arbiter_if.master            fifo_if
);

  localparam int unsigned IdxW  = $clog2(NUM_REQ);
  localparam int unsigned BeatW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e                  state_q, state_d;
  logic [NUM_REQ-1:0]      gnt_q, gnt_d;
  logic [IdxW-1:0]         gnt_idx_q, gnt_idx_d;
  logic [IdxW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [BeatW-1:0]        beat_q, beat_d;
  logic [DATA_WIDTH-1:0]   din_q, din_d;
  logic                    wr_en_q, wr_en_d;
  logic                    err_flag_q, err_flag_d;

  logic                    space;
  logic                    granted_req;
  logic                    pop_fire;
  logic                    last_beat;
  logic                    sel_found;
  logic [IdxW-1:0]         sel_idx;
  int unsigned             cand;

  // First requester at or above rr_ptr, wrapping around.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = (32'(rr_ptr_q) + i) % NUM_REQ;
      if (!sel_found && req_i[IdxW'(cand)]) begin
        sel_found = 1'b1;
        sel_idx   = IdxW'(cand);
      end
    end
  end

  // A write still in flight occupies the last free slot when almost_full is up.
  assign space       = !fifo_if.full && !(fifo_if.almost_full && wr_en_q);
  assign granted_req = req_i[gnt_idx_q];
  assign pop_fire    = (state_q == StGrant) && granted_req && space && !clear_i;
  assign last_beat   = (beat_q == BeatW'(MAX_BURST - 1));
  assign pop_o       = pop_fire ? gnt_q : '0;

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    gnt_idx_d  = gnt_idx_q;
    rr_ptr_d   = rr_ptr_q;
    beat_d     = beat_q;
    din_d      = din_q;
    wr_en_d    = 1'b0;
    err_flag_d = err_flag_q | fifo_if.wr_err;

    unique case (state_q)
      StIdle: begin
        if (sel_found) begin
          state_d   = StGrant;
          gnt_d     = NUM_REQ'(1) << sel_idx;
          gnt_idx_d = sel_idx;
          beat_d    = '0;
        end
      end
      StGrant: begin
        if (pop_fire) begin
          wr_en_d = 1'b1;
          din_d   = req_data_i[32'(gnt_idx_q) * DATA_WIDTH +: DATA_WIDTH];
          beat_d  = beat_q + 1'b1;
        end
        if (!granted_req || (pop_fire && last_beat)) begin
          state_d  = StIdle;
          gnt_d    = '0;
          beat_d   = '0;
          rr_ptr_d = (gnt_idx_q == IdxW'(NUM_REQ - 1)) ? '0 : gnt_idx_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge wr_clk_i) begin
    if (clear_i) begin
      state_q    <= StIdle;
      gnt_q      <= '0;
      gnt_idx_q  <= '0;
      rr_ptr_q   <= '0;
      beat_q     <= '0;
      din_q      <= '0;
      wr_en_q    <= 1'b0;
      err_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      gnt_idx_q  <= gnt_idx_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_q     <= beat_d;
      din_q      <= din_d;
      wr_en_q    <= wr_en_d;
      err_flag_q <= err_flag_d;
    end
  end

  assign gnt_o         = gnt_q;
  assign busy_o        = (state_q == StGrant);
  assign err_flag_o    = err_flag_q;
  assign fifo_if.din   = din_q;
  assign fifo_if.wr_en = wr_en_q;

`ifdef AFIFO_WR_STATS_EN
  logic [15:0] ack_cnt_q, ack_cnt_d;
  logic [7:0]  err_cnt_q, err_cnt_d;

  always_comb begin
    ack_cnt_d = ack_cnt_q;
    err_cnt_d = err_cnt_q;
    if (fifo_if.wr_ack) ack_cnt_d = ack_cnt_q + 16'd1;
    if (fifo_if.wr_err && (err_cnt_q != 8'hff)) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge wr_clk_i) begin
    if (clear_i) begin
      ack_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      ack_cnt_q <= ack_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign ack_cnt_o = ack_cnt_q;
  assign err_cnt_o = err_cnt_q;
`else
  logic unused_wr_ack;
  assign unused_wr_ack = fifo_if.wr_ack;
`endif

endmodule
